// File: rtl/mem_bus_arbiter.sv
// Serializes instruction-fetch and data-port requests onto one SRAM-style bus.
// Data has priority; a starvation limit forces a fetch, and a timeout aborts a hung slave.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT    = 16,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req_i,
  input  logic [31:0] inst_addr_i,
  output logic [31:0] inst_rdata_o,
  output logic        inst_ack_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_sel_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_ack_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        stall_if_o,
  output logic        stall_mem_o,
  output logic        bus_err_o
);

  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam int unsigned SW = $clog2(STARVE_LIM + 1);

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  state_e        state_q, state_d;
  logic          grant_data_q, grant_data_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          bus_req_q, bus_req_d;
  logic          bus_we_q, bus_we_d;
  logic [3:0]    bus_sel_q, bus_sel_d;
  logic [31:0]   bus_addr_q, bus_addr_d;
  logic [31:0]   bus_wdata_q, bus_wdata_d;
  logic          inst_ack_q, inst_ack_d;
  logic          data_ack_q, data_ack_d;
  logic [31:0]   inst_rdata_q, inst_rdata_d;
  logic [31:0]   data_rdata_q, data_rdata_d;
  logic          bus_err_q, bus_err_d;

  logic          finish;
  logic          err;
  logic [31:0]   rdata;

  always_comb begin
    state_d      = state_q;
    grant_data_d = grant_data_q;
    tcnt_d       = tcnt_q;
    starve_d     = starve_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_sel_d    = bus_sel_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    inst_ack_d   = 1'b0;
    data_ack_d   = 1'b0;
    inst_rdata_d = '0;
    data_rdata_d = '0;
    bus_err_d    = 1'b0;
    finish       = 1'b0;
    err          = 1'b0;
    rdata        = '0;

    unique case (state_q)
      StIdle: begin
        if (!inst_req_i) starve_d = '0;
        if (data_req_i && ((starve_q < SW'(STARVE_LIM)) || !inst_req_i)) begin
          state_d      = StBus;
          grant_data_d = 1'b1;
          tcnt_d       = '0;
          bus_req_d    = 1'b1;
          bus_we_d     = data_we_i;
          bus_sel_d    = data_sel_i;
          bus_addr_d   = data_addr_i;
          bus_wdata_d  = data_wdata_i;
          if (inst_req_i && (starve_q < SW'(STARVE_LIM))) starve_d = starve_q + SW'(1);
        end else if (inst_req_i) begin
          state_d      = StBus;
          grant_data_d = 1'b0;
          tcnt_d       = '0;
          starve_d     = '0;
          bus_req_d    = 1'b1;
          bus_we_d     = 1'b0;
          bus_sel_d    = 4'hF;
          bus_addr_d   = inst_addr_i;
          bus_wdata_d  = '0;
        end
      end
      StBus: begin
        if (bus_ack_i) begin
          finish = 1'b1;
          rdata  = bus_we_q ? 32'h0 : bus_rdata_i;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          finish = 1'b1;
          err    = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
        if (finish) begin
          state_d     = StResp;
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          bus_sel_d   = '0;
          bus_addr_d  = '0;
          bus_wdata_d = '0;
          bus_err_d   = err;
          if (grant_data_q) begin
            data_ack_d   = 1'b1;
            data_rdata_d = rdata;
          end else begin
            inst_ack_d   = 1'b1;
            inst_rdata_d = rdata;
          end
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      grant_data_q <= 1'b0;
      tcnt_q       <= '0;
      starve_q     <= '0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_sel_q    <= '0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      inst_ack_q   <= 1'b0;
      data_ack_q   <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_data_q <= grant_data_d;
      tcnt_q       <= tcnt_d;
      starve_q     <= starve_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_sel_q    <= bus_sel_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      inst_ack_q   <= inst_ack_d;
      data_ack_q   <= data_ack_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign bus_req_o    = bus_req_q;
  assign bus_we_o     = bus_we_q;
  assign bus_sel_o    = bus_sel_q;
  assign bus_addr_o   = bus_addr_q;
  assign bus_wdata_o  = bus_wdata_q;
  assign inst_ack_o   = inst_ack_q;
  assign data_ack_o   = data_ack_q;
  assign inst_rdata_o = inst_rdata_q;
  assign data_rdata_o = data_rdata_q;
  assign bus_err_o    = bus_err_q;
  assign stall_if_o   = inst_req_i & ~inst_ack_q;
  assign stall_mem_o  = data_req_i & ~data_ack_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: fetch, priority, starvation, timeout, reset, stray acks.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        inst_req_i;
  logic [31:0] inst_addr_i;
  logic [31:0] inst_rdata_o;
  logic        inst_ack_o;
  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_sel_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [31:0] data_rdata_o;
  logic        data_ack_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic        stall_if_o;
  logic        stall_mem_o;
  logic        bus_err_o;

  int checks = 0;
  int errors = 0;

  mem_bus_arbiter #(
    .TIMEOUT    (16),
    .STARVE_LIM (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req_i   (inst_req_i),
    .inst_addr_i  (inst_addr_i),
    .inst_rdata_o (inst_rdata_o),
    .inst_ack_o   (inst_ack_o),
    .data_req_i   (data_req_i),
    .data_we_i    (data_we_i),
    .data_sel_i   (data_sel_i),
    .data_addr_i  (data_addr_i),
    .data_wdata_i (data_wdata_i),
    .data_rdata_o (data_rdata_o),
    .data_ack_o   (data_ack_o),
    .bus_req_o    (bus_req_o),
    .bus_we_o     (bus_we_o),
    .bus_sel_o    (bus_sel_o),
    .bus_addr_o   (bus_addr_o),
    .bus_wdata_o  (bus_wdata_o),
    .bus_rdata_i  (bus_rdata_i),
    .bus_ack_i    (bus_ack_i),
    .stall_if_o   (stall_if_o),
    .stall_mem_o  (stall_mem_o),
    .bus_err_o    (bus_err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Slave completes the current bus cycle with read data d.
  task automatic slave_ack(input logic [31:0] d);
    bus_ack_i   = 1'b1;
    bus_rdata_i = d;
    step();
    bus_ack_i   = 1'b0;
    bus_rdata_i = '0;
  endtask

  initial begin
    int          cnt;
    int          nacks;
    logic [9:0]  seq;

    rst          = 1'b0;
    inst_req_i   = 1'b0;
    inst_addr_i  = '0;
    data_req_i   = 1'b0;
    data_we_i    = 1'b0;
    data_sel_i   = '0;
    data_addr_i  = '0;
    data_wdata_i = '0;
    bus_rdata_i  = '0;
    bus_ack_i    = 1'b0;

    // Reset state
    #12;
    chk("rst_bus_req", bus_req_o, 0);
    chk("rst_inst_ack", inst_ack_o, 0);
    chk("rst_data_ack", data_ack_o, 0);
    chk("rst_bus_err", bus_err_o, 0);
    chk("rst_bus_addr", bus_addr_o, 0);
    chk("rst_bus_sel", bus_sel_o, 0);
    step();
    rst = 1'b1;
    step();

    // 1: single fetch, slave acks one cycle after bus_req_o
    inst_req_i  = 1'b1;
    inst_addr_i = 32'h100;
    #1;
    chk("t1_stall_if_idle", stall_if_o, 1);
    step();
    chk("t1_bus_req", bus_req_o, 1);
    chk("t1_bus_addr", bus_addr_o, 32'h100);
    chk("t1_bus_sel", bus_sel_o, 4'hF);
    chk("t1_bus_we", bus_we_o, 0);
    chk("t1_stall_if_bus", stall_if_o, 1);
    step();
    chk("t1_bus_req_hold", bus_req_o, 1);
    chk("t1_no_early_ack", inst_ack_o, 0);
    slave_ack(32'hCAFE0001);
    chk("t1_inst_ack", inst_ack_o, 1);
    chk("t1_inst_rdata", inst_rdata_o, 32'hCAFE0001);
    chk("t1_stall_if_ack", stall_if_o, 0);
    chk("t1_bus_req_resp", bus_req_o, 0);
    chk("t1_data_ack", data_ack_o, 0);
    inst_req_i = 1'b0;
    step();
    chk("t1_ack_pulse", inst_ack_o, 0);
    chk("t1_rdata_clr", inst_rdata_o, 0);

    // 2: simultaneous requests, data write wins, fetch follows
    data_req_i   = 1'b1;
    data_we_i    = 1'b1;
    data_sel_i   = 4'b0011;
    data_addr_i  = 32'h200;
    data_wdata_i = 32'hDEADBEEF;
    inst_req_i   = 1'b1;
    inst_addr_i  = 32'h104;
    step();
    chk("t2_data_we", bus_we_o, 1);
    chk("t2_data_addr", bus_addr_o, 32'h200);
    chk("t2_data_wdata", bus_wdata_o, 32'hDEADBEEF);
    chk("t2_data_sel", bus_sel_o, 4'b0011);
    chk("t2_stall_if", stall_if_o, 1);
    chk("t2_stall_mem", stall_mem_o, 1);
    slave_ack(32'h12345678);
    chk("t2_data_ack", data_ack_o, 1);
    chk("t2_write_rdata", data_rdata_o, 0);
    chk("t2_stall_mem_ack", stall_mem_o, 0);
    chk("t2_inst_waits", inst_ack_o, 0);
    chk("t2_stall_if_loser", stall_if_o, 1);
    data_req_i = 1'b0;
    data_we_i  = 1'b0;
    step();
    chk("t2_idle_bus_req", bus_req_o, 0);
    step();
    chk("t2_inst_bus_req", bus_req_o, 1);
    chk("t2_inst_addr", bus_addr_o, 32'h104);
    chk("t2_inst_we", bus_we_o, 0);
    chk("t2_inst_sel", bus_sel_o, 4'hF);
    slave_ack(32'h0BADF00D);
    chk("t2_inst_ack", inst_ack_o, 1);
    chk("t2_inst_rdata", inst_rdata_o, 32'h0BADF00D);
    inst_req_i = 1'b0;
    step();

    // 3: data held with fetch pending; slave always acks
    data_req_i  = 1'b1;
    data_addr_i = 32'h300;
    data_sel_i  = 4'hF;
    inst_req_i  = 1'b1;
    inst_addr_i = 32'h108;
    bus_ack_i   = 1'b1;
    bus_rdata_i = 32'h55AA55AA;
    nacks = 0;
    seq   = '0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (inst_ack_o || data_ack_o) begin
        nacks++;
        seq = {seq[8:0], inst_ack_o};
      end
    end
    chk("t3_ack_count", nacks, 10);
    chk("t3_grant_pattern", {22'h0, seq}, {22'h0, 10'b0000100001});
    data_req_i  = 1'b0;
    inst_req_i  = 1'b0;
    bus_ack_i   = 1'b0;
    bus_rdata_i = '0;
    step();

    // 4: slave never acks -> timeout after 16 bus cycles
    data_req_i  = 1'b1;
    data_addr_i = 32'h400;
    bus_rdata_i = 32'hFFFFFFFF;
    cnt = 0;
    step();
    for (int i = 0; i < 40; i++) begin
      if (data_ack_o) break;
      if (bus_req_o) cnt++;
      step();
    end
    chk("t4_req_cycles", cnt, 16);
    chk("t4_data_ack", data_ack_o, 1);
    chk("t4_bus_err", bus_err_o, 1);
    chk("t4_rdata_zero", data_rdata_o, 0);
    data_req_i  = 1'b0;
    bus_rdata_i = '0;
    step();
    chk("t4_err_pulse", bus_err_o, 0);
    data_req_i  = 1'b1;
    data_addr_i = 32'h404;
    step();
    chk("t4_next_req", bus_req_o, 1);
    slave_ack(32'hA5A5A5A5);
    chk("t4_next_ack", data_ack_o, 1);
    chk("t4_next_rdata", data_rdata_o, 32'hA5A5A5A5);
    chk("t4_next_no_err", bus_err_o, 0);
    data_req_i = 1'b0;
    step();

    // 5: reset pulse mid-bus-cycle
    data_req_i  = 1'b1;
    data_addr_i = 32'h500;
    step();
    chk("t5_bus_req", bus_req_o, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("t5_async_drop", bus_req_o, 0);
    chk("t5_no_ack", data_ack_o, 0);
    step();
    rst = 1'b1;
    #1;
    chk("t5_still_idle", bus_req_o, 0);
    step();
    chk("t5_regrant", bus_req_o, 1);
    chk("t5_regrant_addr", bus_addr_o, 32'h500);
    slave_ack(32'h00C0FFEE);
    chk("t5_ack", data_ack_o, 1);
    chk("t5_rdata", data_rdata_o, 32'h00C0FFEE);
    data_req_i = 1'b0;
    step();

    // 6: stray bus_ack_i while idle and in RESP
    bus_ack_i = 1'b1;
    step();
    step();
    chk("t6_idle_no_req", bus_req_o, 0);
    chk("t6_idle_no_dack", data_ack_o, 0);
    chk("t6_idle_no_iack", inst_ack_o, 0);
    bus_ack_i   = 1'b0;
    inst_req_i  = 1'b1;
    inst_addr_i = 32'h600;
    step();
    chk("t6_grant", bus_req_o, 1);
    bus_ack_i   = 1'b1;
    bus_rdata_i = 32'h66666666;
    step();
    chk("t6_ack", inst_ack_o, 1);
    inst_req_i  = 1'b0;
    bus_rdata_i = 32'h77777777;
    step();
    chk("t6_resp_stray_iack", inst_ack_o, 0);
    chk("t6_resp_stray_req", bus_req_o, 0);
    chk("t6_resp_stray_rdata", inst_rdata_o, 0);
    bus_ack_i = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
